inst_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-request IF/IW fetch handshake of the multi-cycle core with a prefetching engine. It keeps up to `MAX_OUTSTANDING` requests in flight on the instruction memory channel and buffers returned words with their PCs in a `FIFO_DEPTH`-entry queue. It presents them to the core decoder over a valid/ready port and supports a redirect for taken branches and jumps that flushes all queued and in-flight wrong-path words.

---
 rtl/inst_prefetch_unit.sv | 146 ++++++++++++++
 tb/tb_inst_prefetch_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_unit.sv
// Prefetching instruction-fetch front end: keeps several memory requests in flight and queues
// returned words with their PCs for the decoder; a redirect flushes queued and in-flight words.
module inst_prefetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_discard_cnt,
    output logic [31:0] perf_starve_cnt
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]     issue_pc_q, issue_pc_d, resp_pc_q, resp_pc_d;
    logic [OutW-1:0] outstanding_q, outstanding_d, stale_q, stale_d, live_cnt;
    logic            hold_q, hold_d, hold_stale_q, hold_stale_d;
    logic [31:0]     hold_pc_q, hold_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     req_cnt_q, req_cnt_d, disc_cnt_q, disc_cnt_d, starve_cnt_q, starve_cnt_d;
    logic [31:0]     fifo_pc   [FIFO_DEPTH];
    logic [31:0]     fifo_inst [FIFO_DEPTH];
    logic            can_issue, req_acc, rsp_acc, drop, push, pop;

    // Space check counts live in-flight words so a live response always finds a FIFO slot.
    assign live_cnt  = outstanding_q - stale_q;
    assign can_issue = !redirect_valid && (32'(outstanding_q) < MAX_OUTSTANDING) &&
                       (32'(count_q) + 32'(live_cnt) < FIFO_DEPTH);

    assign Inst_Req_Valid = !rst && (hold_q || can_issue);
    assign PC             = hold_q ? hold_pc_q : issue_pc_q;
    assign Inst_Ready     = !rst && (outstanding_q != '0);
    assign fetch_valid    = !rst && (count_q != '0);
    assign fetch_inst     = fetch_valid ? fifo_inst[rd_ptr_q] : '0;
    assign fetch_pc       = fetch_valid ? fifo_pc[rd_ptr_q] : '0;

    assign req_acc = Inst_Req_Valid && Inst_Req_Ready;
    assign rsp_acc = Inst_Valid && Inst_Ready;
    assign drop    = rsp_acc && ((stale_q != '0) || redirect_valid);
    assign push    = rsp_acc && !drop;
    assign pop     = fetch_valid && fetch_ready;

    assign perf_req_cnt     = req_cnt_q;
    assign perf_discard_cnt = disc_cnt_q;
    assign perf_starve_cnt  = starve_cnt_q;

    always_comb begin
        outstanding_d = outstanding_q + OutW'(req_acc) - OutW'(rsp_acc);
        stale_d       = stale_q + OutW'(req_acc && hold_q && hold_stale_q)
                                - OutW'(drop && (stale_q != '0));
        issue_pc_d    = issue_pc_q;
        resp_pc_d     = resp_pc_q;
        hold_d        = hold_q;
        hold_pc_d     = hold_pc_q;
        hold_stale_d  = hold_stale_q;
        rd_ptr_d      = rd_ptr_q + PtrW'(pop);
        wr_ptr_d      = wr_ptr_q + PtrW'(push);
        count_d       = count_q + CntW'(push) - CntW'(pop);
        req_cnt_d     = req_cnt_q + 32'(req_acc);
        disc_cnt_d    = disc_cnt_q + 32'(drop);
        starve_cnt_d  = starve_cnt_q + 32'(fetch_ready && !fetch_valid);

        if (req_acc) begin
            hold_d       = 1'b0;
            hold_stale_d = 1'b0;
            if (!(hold_q && hold_stale_q)) begin
                issue_pc_d = issue_pc_q + 32'd4;
            end
        end else if (Inst_Req_Valid && !hold_q) begin
            hold_d       = 1'b1;
            hold_pc_d    = PC;
            hold_stale_d = 1'b0;
        end

        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end

        // Everything in flight after this edge, including a held request, is wrong-path.
        if (redirect_valid) begin
            issue_pc_d   = redirect_pc & 32'hFFFF_FFFC;
            resp_pc_d    = redirect_pc & 32'hFFFF_FFFC;
            stale_d      = outstanding_d;
            hold_stale_d = hold_d;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
            hold_q        <= 1'b0;
            hold_pc_q     <= '0;
            hold_stale_q  <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            req_cnt_q     <= '0;
            disc_cnt_q    <= '0;
            starve_cnt_q  <= '0;
        end else begin
            issue_pc_q    <= issue_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            hold_q        <= hold_d;
            hold_pc_q     <= hold_pc_d;
            hold_stale_q  <= hold_stale_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            req_cnt_q     <= req_cnt_d;
            disc_cnt_q    <= disc_cnt_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= resp_pc_q;
            fifo_inst[wr_ptr_q] <= Instruction;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed and randomised bench for inst_prefetch_unit; a queue-based transaction model is
// compared against the DUT every cycle, with literal expectations for the key scenarios.
module tb_inst_prefetch_unit;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid, Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid, Inst_Ready;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_inst, fetch_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_req_cnt, perf_discard_cnt, perf_starve_cnt;

    always #5 clk = ~clk;

    inst_prefetch_unit #(
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .PC               (PC),
        .Inst_Req_Valid   (Inst_Req_Valid),
        .Inst_Req_Ready   (Inst_Req_Ready),
        .Instruction      (Instruction),
        .Inst_Valid       (Inst_Valid),
        .Inst_Ready       (Inst_Ready),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_inst       (fetch_inst),
        .fetch_pc         (fetch_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .perf_req_cnt     (perf_req_cnt),
        .perf_discard_cnt (perf_discard_cnt),
        .perf_starve_cnt  (perf_starve_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Memory: in-order responder, Instruction = address ^ key after a configurable latency.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int unsigned lat_lo = 0, lat_hi = 0;
    logic [31:0] key = 32'h0;

    always @(negedge clk) begin
        if (Inst_Valid && Inst_Ready && mq_addr.size() > 0) begin
            mq_addr.delete(0);
            mq_due.delete(0);
        end
        if (Inst_Req_Valid && Inst_Req_Ready) begin
            mq_addr.push_back(PC);
            mq_due.push_back(cyc + 1 + int'($urandom_range(lat_hi, lat_lo)));
        end
        check1("inflight_bound", mq_addr.size() <= int'(MAXO), 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            Inst_Valid  = 1'b1;
            Instruction = mq_addr[0] ^ key;
        end else begin
            Inst_Valid  = 1'b0;
            Instruction = $urandom();
        end
    endtask

    // Reference model: in-flight requests as a queue of live/stale flags, FIFO as a queue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_fifo[$];
    bit          m_fl[$];
    logic [31:0] m_issue, m_resp, m_hold_pc, m_req, m_disc, m_starve;
    bit          m_hold = 1'b0, m_hold_stale = 1'b0, m_in_rst = 1'b0;

    always @(negedge clk) begin : model_chk
        logic        e_rv, e_ir, e_fv, lv;
        logic [31:0] e_pc, e_fpc, e_finst;
        int          live;
        ent_t        h;
        if (rst) begin
            check1("rst_req_valid", Inst_Req_Valid, 1'b0);
            check1("rst_inst_ready", Inst_Ready, 1'b0);
            check1("rst_fetch_valid", fetch_valid, 1'b0);
            check32("rst_fetch_inst", fetch_inst, 32'h0);
            check32("rst_fetch_pc", fetch_pc, 32'h0);
            if (m_in_rst) begin
                check32("rst_req_cnt", perf_req_cnt, 32'h0);
                check32("rst_disc_cnt", perf_discard_cnt, 32'h0);
                check32("rst_starve_cnt", perf_starve_cnt, 32'h0);
            end
            m_fifo.delete();
            m_fl.delete();
            m_issue = RPC; m_resp = RPC; m_hold = 1'b0; m_hold_stale = 1'b0;
            m_req = 0; m_disc = 0; m_starve = 0;
            m_in_rst = 1'b1;
        end else begin
            m_in_rst = 1'b0;
            live = 0;
            foreach (m_fl[i]) if (m_fl[i]) live++;
            e_rv    = m_hold || (!redirect_valid && m_fl.size() < int'(MAXO) &&
                                 m_fifo.size() + live < int'(DEPTH));
            e_pc    = m_hold ? m_hold_pc : m_issue;
            e_ir    = m_fl.size() != 0;
            e_fv    = m_fifo.size() != 0;
            e_fpc   = e_fv ? m_fifo[0].pc : 32'h0;
            e_finst = e_fv ? m_fifo[0].inst : 32'h0;
            check1("req_valid", Inst_Req_Valid, e_rv);
            if (e_rv) check32("req_pc", PC, e_pc);
            check1("inst_ready", Inst_Ready, e_ir);
            check1("fetch_valid", fetch_valid, e_fv);
            check32("fetch_pc", fetch_pc, e_fpc);
            check32("fetch_inst", fetch_inst, e_finst);
            check32("perf_req", perf_req_cnt, m_req);
            check32("perf_discard", perf_discard_cnt, m_disc);
            check32("perf_starve", perf_starve_cnt, m_starve);

            if (fetch_ready && !e_fv) m_starve++;
            if (e_fv && fetch_ready) m_fifo.delete(0);
            if (Inst_Valid && e_ir) begin
                lv = m_fl[0];
                m_fl.delete(0);
                if (!lv || redirect_valid) begin
                    m_disc++;
                end else begin
                    h.pc = m_resp; h.inst = Instruction;
                    m_fifo.push_back(h);
                    m_resp += 32'd4;
                end
            end
            if (e_rv && Inst_Req_Ready) begin
                lv = !(m_hold && m_hold_stale);
                m_fl.push_back(lv);
                if (lv) m_issue += 32'd4;
                m_req++;
                m_hold = 1'b0; m_hold_stale = 1'b0;
            end else if (e_rv && !m_hold) begin
                m_hold = 1'b1; m_hold_pc = e_pc; m_hold_stale = 1'b0;
            end
            if (redirect_valid) begin
                m_fifo.delete();
                foreach (m_fl[i]) m_fl[i] = 1'b0;
                m_issue = redirect_pc & 32'hFFFF_FFFC;
                m_resp  = redirect_pc & 32'hFFFF_FFFC;
                if (m_hold) m_hold_stale = 1'b1;
            end
        end
    end

    task automatic reset_dut();
        tick();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        Inst_Valid = 1'b0;
    endtask

    // Follows the presented PC stream; it must be start, start+4, ... with matching words.
    task automatic watch(input int n, input logic [31:0] start, input string name, output int seen);
        logic [31:0] exp;
        exp = start;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            @(negedge clk);
            if (fetch_valid) begin
                check32({name, "_pc"}, fetch_pc, exp);
                check32({name, "_inst"}, fetch_inst, exp ^ key);
                if (fetch_ready) begin
                    exp += 32'd4;
                    seen++;
                end
            end
        end
    endtask

    initial begin
        int seen;
        int found;
        rst = 1'b1; Inst_Req_Ready = 1'b1; fetch_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0; Inst_Valid = 1'b0; Instruction = 32'h0;

        // Zero-wait streaming with Instruction == PC.
        reset_dut();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check1("p1_first_req_valid", Inst_Req_Valid, 1'b1);
                check32("p1_first_pc", PC, RPC);
            end
            check1("p1_fetch_valid", fetch_valid, k >= 2);
            if (k >= 2) begin
                check32("p1_fetch_pc", fetch_pc, 32'(4 * (k - 2)));
                check32("p1_fetch_inst", fetch_inst, 32'(4 * (k - 2)));
            end
            tick();
        end

        // Consumer stall: exactly four requests, then a gap-free drain.
        key = 32'h5A5A_0000;
        reset_dut();
        fetch_ready = 1'b0;
        repeat (19) tick();
        @(negedge clk);
        check32("p2_req_cnt", perf_req_cnt, 32'd4);
        check1("p2_req_valid", Inst_Req_Valid, 1'b0);
        check1("p2_fetch_valid", fetch_valid, 1'b1);
        check32("p2_fetch_pc", fetch_pc, 32'h0);
        tick();
        fetch_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("p2_drain_valid", fetch_valid, 1'b1);
            check32("p2_drain_pc", fetch_pc, 32'(4 * i));
            check32("p2_drain_inst", fetch_inst, 32'(4 * i) ^ 32'h5A5A_0000);
            tick();
        end

        // Reset in the middle of traffic with a full FIFO.
        fetch_ready = 1'b0; lat_lo = 0; lat_hi = 3;
        repeat (8) tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0; mq_addr.delete(); mq_due.delete(); Inst_Valid = 1'b0;
        fetch_ready = 1'b1; lat_hi = 0;
        @(negedge clk);
        check32("p2b_req_cnt", perf_req_cnt, 32'h0);
        check32("p2b_disc_cnt", perf_discard_cnt, 32'h0);
        check32("p2b_starve_cnt", perf_starve_cnt, 32'h0);
        check1("p2b_fetch_valid", fetch_valid, 1'b0);
        check1("p2b_req_valid", Inst_Req_Valid, 1'b1);
        check32("p2b_pc", PC, RPC);
        watch(10, RPC, "p2b", seen);
        check1("p2b_restart_flow", seen >= 6, 1'b1);

        // Redirect with two requests in flight.
        reset_dut();
        lat_lo = 1; lat_hi = 1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (mq_addr.size() == 2) found = 1;
        end
        check32("p3_inflight_at_redirect", 32'(mq_addr.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h101;
        @(negedge clk);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check1("p3_fv_after_redirect", fetch_valid, 1'b0);
        watch(15, 32'h100, "p3", seen);
        check32("p3_discards", perf_discard_cnt, 32'd2);
        check1("p3_flow", seen >= 5, 1'b1);

        // Memory not ready for five cycles, redirect while the request is held.
        tick();
        lat_lo = 0; lat_hi = 0;
        Inst_Req_Ready = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (Inst_Req_Valid) found = 1;
            else tick();
        end
        check1("p4_req_seen", found == 1, 1'b1);
        for (int j = 1; j < 5; j++) begin
            tick();
            redirect_valid = (j == 2);
            redirect_pc = 32'h200;
            @(negedge clk);
            check1("p4_hold_valid", Inst_Req_Valid, 1'b1);
        end
        tick();
        redirect_valid = 1'b0;
        Inst_Req_Ready = 1'b1;
        @(negedge clk);
        check1("p4_held_accept", Inst_Req_Valid, 1'b1);
        tick();
        @(negedge clk);
        check1("p4_next_valid", Inst_Req_Valid, 1'b1);
        check32("p4_next_pc", PC, 32'h200);
        watch(12, 32'h200, "p4", seen);
        check1("p4_flow", seen >= 4, 1'b1);

        // PC wrap-around past the top of the address space.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        watch(10, 32'hFFFF_FFF8, "p5", seen);
        check1("p5_flow", seen >= 4, 1'b1);

        // Random traffic against the model.
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (rst) begin
                rst = 1'b0;
                mq_addr.delete();
                mq_due.delete();
                Inst_Valid = 1'b0;
            end else if ($urandom_range(199, 0) == 0) begin
                rst = 1'b1;
            end
            Inst_Req_Ready = ($urandom_range(9, 0) < 7);
            fetch_ready    = ($urandom_range(9, 0) < 6);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = $urandom();
        end
        tick();
        redirect_valid = 1'b0;
        rst = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
